// File: rtl/barrel_pkg.sv
// Shared constants and index helper for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_SHIFT  = 1'b1;

  // Source element for one output element; zero set means zero-fill.
  typedef struct packed {
    logic        zero;
    logic [31:0] idx;
  } src_sel_t;

  // Output element j takes input element idx; wrap-around is zeroed in shift mode.
  function automatic src_sel_t src_index(input int unsigned j,
                                         input int unsigned amt,
                                         input logic        dir,
                                         input logic        mode,
                                         input int unsigned n);
    src_sel_t r;
    r.zero = 1'b0;
    r.idx  = '0;
    if (dir == DIR_LEFT) begin
      if (j >= amt) begin
        r.idx = j - amt;
      end else begin
        r.idx  = j + n - amt;
        r.zero = (mode == MODE_SHIFT);
      end
    end else begin
      if (j + amt < n) begin
        r.idx = j + amt;
      end else begin
        r.idx  = j + amt - n;
        r.zero = (mode == MODE_SHIFT);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready vector bus carrying per-vector shift control and a sideband tag.
interface barrel_shifter_pipe_if #(
  parameter int unsigned N         = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_WIDTH = 4
);
  localparam int unsigned K = $clog2(N);

  logic                 valid;
  logic                 ready;
  logic [N*WIDTH-1:0]   data;
  logic [K-1:0]         shamt;
  logic                 dir;
  logic                 mode;
  logic [TAG_WIDTH-1:0] tag;

  modport master (output valid, data, shamt, dir, mode, tag, input ready);
  modport slave  (input valid, data, shamt, dir, mode, tag, output ready);
endinterface

// File: rtl/barrel_shifter_stage.sv
// One pipeline slice: conditionally shifts by 2**STAGE_NUM and registers the vector.
module barrel_shifter_stage
  import barrel_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned K         = 4,
  parameter int unsigned STAGE_NUM = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 valid_i,
  input  logic [N*WIDTH-1:0]   data_i,
  input  logic [K-1:0]         shamt_i,
  input  logic                 dir_i,
  input  logic                 mode_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_q,
  output logic [N*WIDTH-1:0]   data_q,
  output logic [K-1:0]         shamt_q,
  output logic                 dir_q,
  output logic                 mode_q,
  output logic [TAG_WIDTH-1:0] tag_q
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned AMT = 2 ** STAGE_NUM;

  typedef logic [N-1:0][WIDTH-1:0] vec_t;

  vec_t                 in_vec;
  vec_t                 shifted_c;
  src_sel_t             sel;
  logic                 valid_d;
  logic [N*WIDTH-1:0]   data_d;
  logic [K-1:0]         shamt_d;
  logic                 dir_d;
  logic                 mode_d;
  logic [TAG_WIDTH-1:0] tag_d;

  // Element-wise move by AMT when this stage's shift-amount bit is set.
  always_comb begin
    in_vec    = data_i;
    shifted_c = in_vec;
    sel       = '0;
    if (shamt_i[STAGE_NUM]) begin
      for (int unsigned j = 0; j < N; j++) begin
        sel = src_index(j, AMT, dir_i, mode_i, N);
        shifted_c[IW'(j)] = sel.zero ? '0 : in_vec[IW'(sel.idx)];
      end
    end
  end

  // Load a new slice whenever this stage is ready; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    if (en) begin
      valid_d = valid_i;
      data_d  = shifted_c;
      shamt_d = shamt_i;
      dir_d   = dir_i;
      mode_d  = mode_i;
      tag_d   = tag_i;
    end
  end

  // Slice register; reset discards whatever is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// K-stage pipelined barrel shifter (rotate / logical shift, left / right) with backpressure.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  barrel_shifter_pipe_if.slave  in_if,
  barrel_shifter_pipe_if.master out_if
);

  localparam int unsigned K  = $clog2(N);
  localparam int unsigned DW = N * WIDTH;

  // Index 0 is the input bus, index k+1 is the register output of stage k.
  logic [K:0]                valid_s;
  logic [K:0][DW-1:0]        data_s;
  logic [K:0][K-1:0]         shamt_s;
  logic [K:0]                dir_s;
  logic [K:0]                mode_s;
  logic [K:0][TAG_WIDTH-1:0] tag_s;
  logic [K-1:0]              ready_c;

  assign valid_s[0] = in_if.valid;
  assign data_s[0]  = in_if.data;
  assign shamt_s[0] = in_if.shamt;
  assign dir_s[0]   = in_if.dir;
  assign mode_s[0]  = in_if.mode;
  assign tag_s[0]   = in_if.tag;

  for (genvar k = 0; k < K; k++) begin : g_stage
    // Unrolled ready chain: a stage can load if the consumer is ready or any slot downstream is empty.
    assign ready_c[k] = out_if.ready || !(&valid_s[K:k+1]);

    barrel_shifter_stage #(
      .N         (N),
      .WIDTH     (WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .K         (K),
      .STAGE_NUM (k)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (ready_c[k]),
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .shamt_i (shamt_s[k]),
      .dir_i   (dir_s[k]),
      .mode_i  (mode_s[k]),
      .tag_i   (tag_s[k]),
      .valid_q (valid_s[k+1]),
      .data_q  (data_s[k+1]),
      .shamt_q (shamt_s[k+1]),
      .dir_q   (dir_s[k+1]),
      .mode_q  (mode_s[k+1]),
      .tag_q   (tag_s[k+1])
    );
  end

  assign in_if.ready  = ready_c[0];
  assign out_if.valid = valid_s[K];
  assign out_if.data  = data_s[K];
  assign out_if.shamt = shamt_s[K];
  assign out_if.dir   = dir_s[K];
  assign out_if.mode  = mode_s[K];
  assign out_if.tag   = tag_s[K];

endmodule
